// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable terminal value.
//
// Counts over 0..MAX_VAL, wrapping modulo (MAX_VAL+1) or saturating at the
// limits depending on SATURATE. Per-edge priority: sync_clr > load > en > hold.
//
// Parameters:
//   WIDTH    - counter width in bits (2..32)
//   MAX_VAL  - terminal count value (1..2**WIDTH-1)
//   SATURATE - 0: wrap at limits, 1: hold at limits
//
// Ports:
//   clk      - rising-edge clock
//   clear_n  - asynchronous active-low reset (count, ovf, unf -> 0)
//   sync_clr - synchronous clear to 0
//   load     - synchronous parallel load (clamped to MAX_VAL)
//   load_val - value loaded when load=1
//   en       - count enable
//   dir_up   - 1: count up, 0: count down
//   count    - registered count value
//   at_max   - combinational, count == MAX_VAL
//   at_zero  - combinational, count == 0
//   ovf      - registered pulse: an up-count event happened at MAX_VAL
//   unf      - registered pulse: a down-count event happened at 0
module updown_counter_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir_up,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (sync_clr) begin
      count_d = '0;
    end else if (load) begin
      // Out-of-range load values clamp so count never leaves 0..MAX_VAL.
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      if (dir_up) begin
        if (count_q == MaxVal) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? MaxVal : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          unf_d   = 1'b1;
          count_d = SATURATE ? '0 : MaxVal;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count   = count_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign at_max  = (count_q == MaxVal);
  assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param. Four instances share one set
// of inputs: full range (255, wrap), MAX_VAL=9 wrap, MAX_VAL=200 saturate and
// MAX_VAL=1 wrap (toggle). Each is tracked by a modulo-arithmetic model.
module tb_updown_counter_param;

  localparam int NInst = 4;
  localparam int MaxV [NInst] = '{255, 9, 200, 1};
  localparam bit SatV [NInst] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       sync_clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       en = 1'b0;
  logic       dir_up = 1'b0;

  logic [7:0] cnt_v [NInst];
  logic [NInst-1:0] at_max_v, at_zero_v, ovf_v, unf_v;

  int m_cnt [NInst];
  bit m_ovf [NInst];
  bit m_unf [NInst];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) u_full (
    .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load), .load_val(load_val),
    .en(en), .dir_up(dir_up), .count(cnt_v[0]), .at_max(at_max_v[0]),
    .at_zero(at_zero_v[0]), .ovf(ovf_v[0]), .unf(unf_v[0])
  );

  updown_counter_param #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap9 (
    .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load), .load_val(load_val),
    .en(en), .dir_up(dir_up), .count(cnt_v[1]), .at_max(at_max_v[1]),
    .at_zero(at_zero_v[1]), .ovf(ovf_v[1]), .unf(unf_v[1])
  );

  updown_counter_param #(.WIDTH(8), .MAX_VAL(200), .SATURATE(1'b1)) u_sat200 (
    .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load), .load_val(load_val),
    .en(en), .dir_up(dir_up), .count(cnt_v[2]), .at_max(at_max_v[2]),
    .at_zero(at_zero_v[2]), .ovf(ovf_v[2]), .unf(unf_v[2])
  );

  updown_counter_param #(.WIDTH(8), .MAX_VAL(1), .SATURATE(1'b0)) u_tog (
    .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load), .load_val(load_val),
    .en(en), .dir_up(dir_up), .count(cnt_v[3]), .at_max(at_max_v[3]),
    .at_zero(at_zero_v[3]), .ovf(ovf_v[3]), .unf(unf_v[3])
  );

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  // Reference next state computed from the counting rules in plain arithmetic.
  function automatic void model_step(input int c, input int mx, input bit sat,
                                     output int n, output bit o, output bit u);
    o = 1'b0;
    u = 1'b0;
    n = c;
    if (sync_clr) begin
      n = 0;
    end else if (load) begin
      n = (int'(load_val) > mx) ? mx : int'(load_val);
    end else if (en) begin
      if (dir_up) begin
        o = (c == mx);
        n = (sat && o) ? mx : (c + 1) % (mx + 1);
      end else begin
        u = (c == 0);
        n = (sat && u) ? 0 : (c + mx) % (mx + 1);
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < NInst; i++) begin
      check("count", i, int'(cnt_v[i]), m_cnt[i]);
      check("ovf", i, int'(ovf_v[i]), int'(m_ovf[i]));
      check("unf", i, int'(unf_v[i]), int'(m_unf[i]));
      check("at_max", i, int'(at_max_v[i]), int'(m_cnt[i] == MaxV[i]));
      check("at_zero", i, int'(at_zero_v[i]), int'(m_cnt[i] == 0));
    end
  endtask

  // One clock: predict from the current inputs, take the edge, compare.
  task automatic cycle();
    int nc [NInst];
    bit no [NInst];
    bit nu [NInst];
    for (int i = 0; i < NInst; i++) model_step(m_cnt[i], MaxV[i], SatV[i], nc[i], no[i], nu[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < NInst; i++) begin
      m_cnt[i] = nc[i];
      m_ovf[i] = no[i];
      m_unf[i] = nu[i];
    end
    check_all();
  endtask

  task automatic drive(input bit sc, input bit ld, input int lv, input bit e, input bit up);
    sync_clr = sc;
    load     = ld;
    load_val = 8'(lv);
    en       = e;
    dir_up   = up;
  endtask

  typedef struct {
    bit sclr; bit ld; int lv; bit en; bit up;
    int cnt; bit ovf; bit unf;
  } vec_t;

  vec_t tbl [$];

  initial begin
    for (int i = 0; i < NInst; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end

    // Reset state while held in reset.
    #12;
    check_all();
    @(negedge clk);
    clear_n = 1'b1;

    // Expected sequence for the MAX_VAL=9 wrap instance.
    tbl.push_back('{0, 1, 7,   0, 0, 7, 0, 0});
    tbl.push_back('{0, 0, 0,   1, 1, 8, 0, 0});
    tbl.push_back('{0, 0, 0,   1, 1, 9, 0, 0});
    tbl.push_back('{0, 0, 0,   1, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0,   1, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0,   1, 0, 9, 0, 1});
    tbl.push_back('{0, 0, 0,   1, 0, 8, 0, 0});
    tbl.push_back('{1, 1, 5,   1, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 250, 1, 1, 9, 0, 0});
    tbl.push_back('{0, 0, 0,   1, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0,   0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0,   1, 0, 9, 0, 1});
    foreach (tbl[k]) begin
      drive(tbl[k].sclr, tbl[k].ld, tbl[k].lv, tbl[k].en, tbl[k].up);
      cycle();
      check("tbl_count", 1, int'(cnt_v[1]), tbl[k].cnt);
      check("tbl_ovf", 1, int'(ovf_v[1]), int'(tbl[k].ovf));
      check("tbl_unf", 1, int'(unf_v[1]), int'(tbl[k].unf));
      check("tbl_at_max", 1, int'(at_max_v[1]), int'(tbl[k].cnt == 9));
    end

    // Saturation at 200, then back off, then priority and clamp.
    drive(0, 1, 199, 0, 0); cycle();
    drive(0, 0, 0, 1, 1);
    cycle(); check("sat_cnt", 2, int'(cnt_v[2]), 200); check("sat_ovf", 2, int'(ovf_v[2]), 0);
    cycle(); check("sat_cnt", 2, int'(cnt_v[2]), 200); check("sat_ovf", 2, int'(ovf_v[2]), 1);
    cycle(); check("sat_cnt", 2, int'(cnt_v[2]), 200); check("sat_ovf", 2, int'(ovf_v[2]), 1);
    drive(0, 0, 0, 1, 0);
    cycle(); check("sat_cnt", 2, int'(cnt_v[2]), 199); check("sat_ovf", 2, int'(ovf_v[2]), 0);
    drive(1, 1, 5, 1, 1);
    cycle(); check("prio_cnt", 2, int'(cnt_v[2]), 0);
    drive(0, 1, 250, 1, 1);
    cycle(); check("clamp_cnt", 2, int'(cnt_v[2]), 200); check("clamp_ovf", 2, int'(ovf_v[2]), 0);

    // Hold at 42 then alternate direction every clock.
    drive(0, 1, 42, 0, 0); cycle();
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("hold_cnt", 0, int'(cnt_v[0]), 42);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, (k % 2) == 0);
      cycle();
      check("alt_cnt", 0, int'(cnt_v[0]), (k % 2) == 0 ? 43 : 42);
    end

    // Asynchronous reset mid-cycle, then count up 3 after release.
    drive(0, 0, 0, 1, 1);
    cycle();
    #2;
    clear_n = 1'b0;
    #1;
    for (int i = 0; i < NInst; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end
    check_all();
    @(posedge clk);
    #1;
    check_all();
    clear_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    check("rst_up3", 0, int'(cnt_v[0]), 3);

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
            int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < ((k / 200) % 2 == 0 ? 8 : 2));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
